// File: rtl/branch_rs_multi_if.sv
// Issue, CDB snoop and result bus of the multi-entry branch reservation station.
// BRANCH_RS_UNSIGNED_EN widens issue_mode to 3 bits (bit 2 = unsigned BGE/BLT).
interface branch_rs_multi_if #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 16,
  parameter int RB_INDEX  = 4
);
`ifdef BRANCH_RS_UNSIGNED_EN
  localparam int MODE_W = 3;
`else
  localparam int MODE_W = 2;
`endif

  logic                        issue_valid;
  logic                        issue_ready;
  logic [MODE_W-1:0]           issue_mode;
  logic [RB_INDEX-1:0]         issue_dest;
  logic [WORD_SIZE-1:0]        issue_vj;
  logic [WORD_SIZE-1:0]        issue_vk;
  logic                        issue_rdyj;
  logic                        issue_rdyk;
  logic [RB_INDEX-1:0]         issue_qj;
  logic [RB_INDEX-1:0]         issue_qk;
  logic [WORD_SIZE*RB_SIZE-1:0] cdb_data;
  logic [RB_SIZE-1:0]          cdb_valid;
  logic                        res_valid;
  logic [RB_INDEX-1:0]         res_dest;
  logic                        res_taken;

  modport master (
    output issue_valid, issue_mode, issue_dest, issue_vj, issue_vk,
           issue_rdyj, issue_rdyk, issue_qj, issue_qk, cdb_data, cdb_valid,
    input  issue_ready, res_valid, res_dest, res_taken
  );

  modport slave (
    input  issue_valid, issue_mode, issue_dest, issue_vj, issue_vk,
           issue_rdyj, issue_rdyk, issue_qj, issue_qk, cdb_data, cdb_valid,
    output issue_ready, res_valid, res_dest, res_taken
  );
endinterface

// File: rtl/branch_rs_multi.sv
// Multi-entry branch reservation station: compacting age-ordered queue, CDB snoop,
// oldest-ready-first select. BRANCH_RS_UNSIGNED_EN adds BGEU/BLTU via issue_mode[2].
module branch_rs_multi #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 16,
  parameter int RB_INDEX  = 4,
  parameter int ENTRIES   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  branch_rs_multi_if.slave          bus,
  output logic [$clog2(ENTRIES):0]  count
);
`ifdef BRANCH_RS_UNSIGNED_EN
  localparam int MODE_W = 3;
`else
  localparam int MODE_W = 2;
`endif
  localparam int CW = $clog2(ENTRIES) + 1;

  typedef struct packed {
    logic                 valid;
    logic [MODE_W-1:0]    mode;
    logic [RB_INDEX-1:0]  dest;
    logic [WORD_SIZE-1:0] vj;
    logic [WORD_SIZE-1:0] vk;
    logic                 rdyj;
    logic                 rdyk;
    logic [RB_INDEX-1:0]  qj;
    logic [RB_INDEX-1:0]  qk;
  } entry_t;

  entry_t              ent [ENTRIES];
  entry_t              sn  [ENTRIES+1];
  entry_t              nxt [ENTRIES];
  entry_t              new_e;
  logic [ENTRIES-1:0]  sel_oh;
  logic                any_sel;
  logic                issue_acc;
  logic                shift;
  logic [CW-1:0]       wr_pos;
  logic [RB_INDEX-1:0] sel_dest;
  logic                sel_taken;

  function automatic logic [WORD_SIZE-1:0] cdb_slot(
    input logic [WORD_SIZE*RB_SIZE-1:0] data,
    input logic [RB_INDEX-1:0]          q
  );
    cdb_slot = '0;
    for (int s = 0; s < RB_SIZE; s++)
      if (q == RB_INDEX'(s)) cdb_slot = data[s*WORD_SIZE +: WORD_SIZE];
  endfunction

  function automatic logic br_cmp(
    input logic [MODE_W-1:0]    m,
    input logic [WORD_SIZE-1:0] a,
    input logic [WORD_SIZE-1:0] b
  );
    logic lt;
`ifdef BRANCH_RS_UNSIGNED_EN
    lt = m[2] ? (a < b) : ($signed(a) < $signed(b));
`else
    lt = $signed(a) < $signed(b);
`endif
    case (m[1:0])
      2'b00:   br_cmp = !lt;
      2'b01:   br_cmp = lt;
      2'b10:   br_cmp = (a == b);
      default: br_cmp = (a != b);
    endcase
  endfunction

  assign bus.issue_ready = (count < CW'(ENTRIES));
  assign issue_acc = bus.issue_valid && bus.issue_ready && !flush;
  assign wr_pos = count - {{(CW-1){1'b0}}, any_sel};

  // Eligibility looks only at registered readiness; CDB captures count next cycle.
  always_comb begin
    sel_oh    = '0;
    any_sel   = 1'b0;
    sel_dest  = '0;
    sel_taken = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!any_sel && ent[i].valid && ent[i].rdyj && ent[i].rdyk) begin
        sel_oh[i] = 1'b1;
        any_sel   = 1'b1;
        sel_dest  = ent[i].dest;
        sel_taken = br_cmp(ent[i].mode, ent[i].vj, ent[i].vk);
      end
    end
  end

  always_comb begin
    new_e       = '0;
    new_e.valid = 1'b1;
    new_e.mode  = bus.issue_mode;
    new_e.dest  = bus.issue_dest;
    new_e.qj    = bus.issue_qj;
    new_e.qk    = bus.issue_qk;
    if (bus.issue_rdyj) begin
      new_e.vj   = bus.issue_vj;
      new_e.rdyj = 1'b1;
    end else if (bus.cdb_valid[bus.issue_qj]) begin
      new_e.vj   = cdb_slot(bus.cdb_data, bus.issue_qj);
      new_e.rdyj = 1'b1;
    end
    if (bus.issue_rdyk) begin
      new_e.vk   = bus.issue_vk;
      new_e.rdyk = 1'b1;
    end else if (bus.cdb_valid[bus.issue_qk]) begin
      new_e.vk   = cdb_slot(bus.cdb_data, bus.issue_qk);
      new_e.rdyk = 1'b1;
    end
  end

  // sn[ENTRIES] is a permanently empty slot shifted into the top on removal.
  always_comb begin
    for (int i = 0; i <= ENTRIES; i++) sn[i] = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      sn[i] = ent[i];
      if (ent[i].valid && !ent[i].rdyj && bus.cdb_valid[ent[i].qj]) begin
        sn[i].vj   = cdb_slot(bus.cdb_data, ent[i].qj);
        sn[i].rdyj = 1'b1;
      end
      if (ent[i].valid && !ent[i].rdyk && bus.cdb_valid[ent[i].qk]) begin
        sn[i].vk   = cdb_slot(bus.cdb_data, ent[i].qk);
        sn[i].rdyk = 1'b1;
      end
    end
  end

  always_comb begin
    shift = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (sel_oh[i]) shift = 1'b1;
      nxt[i] = shift ? sn[i+1] : sn[i];
      if (issue_acc && wr_pos == CW'(i)) nxt[i] = new_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      count         <= '0;
      bus.res_valid <= 1'b0;
      bus.res_dest  <= '0;
      bus.res_taken <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= nxt[i];
      count         <= count - {{(CW-1){1'b0}}, any_sel} + {{(CW-1){1'b0}}, issue_acc};
      bus.res_valid <= any_sel;
      if (any_sel) begin
        bus.res_dest  <= sel_dest;
        bus.res_taken <= sel_taken;
      end
    end
  end
endmodule

// File: tb/tb_branch_rs_multi.sv
// Directed-vector bench for branch_rs_multi with hand-computed expectations.
module tb_branch_rs_multi;
`ifdef BRANCH_RS_UNSIGNED_EN
  localparam int MODE_W = 3;
`else
  localparam int MODE_W = 2;
`endif
  localparam int WS = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [2:0] count;
  int         vec_cnt = 0;
  int         miscmp = 0;

  branch_rs_multi_if #(.WORD_SIZE(32), .RB_SIZE(16), .RB_INDEX(4)) bus ();

  branch_rs_multi #(.WORD_SIZE(32), .RB_SIZE(16), .RB_INDEX(4), .ENTRIES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic [31:0] a;
    logic [31:0] b;
    int          d;
    logic        t;
  } vec_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_mode  = '0;
    bus.issue_dest  = '0;
    bus.issue_vj    = '0;
    bus.issue_vk    = '0;
    bus.issue_rdyj  = 1'b0;
    bus.issue_rdyk  = 1'b0;
    bus.issue_qj    = '0;
    bus.issue_qk    = '0;
    bus.cdb_data    = '0;
    bus.cdb_valid   = '0;
  endtask

  task automatic put(input int m, input int d, input logic [31:0] vj, input logic [31:0] vk,
                     input logic rj, input logic rk, input int qj, input int qk);
    bus.issue_valid = 1'b1;
    bus.issue_mode  = MODE_W'(m);
    bus.issue_dest  = 4'(d);
    bus.issue_vj    = vj;
    bus.issue_vk    = vk;
    bus.issue_rdyj  = rj;
    bus.issue_rdyk  = rk;
    bus.issue_qj    = 4'(qj);
    bus.issue_qk    = 4'(qk);
  endtask

  task automatic cdb(input int slot, input logic [31:0] d, input logic v);
    bus.cdb_data[slot*WS +: WS] = d;
    bus.cdb_valid[slot]         = v;
  endtask

  vec_t tv[$];

  initial begin
    idle();
    reset = 1'b1;
    flush = 1'b0;
    step();
    step();
    chk("rst_count", count, 0);
    chk("rst_ready", bus.issue_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_dest", bus.res_dest, 0);
    chk("rst_res_taken", bus.res_taken, 0);
    reset = 1'b0;

    // BGE 5>=3, both ready
    put(0, 7, 5, 3, 1, 1, 0, 0);
    step();
    idle();
    chk("bge_count_held", count, 1);
    chk("bge_no_early", bus.res_valid, 0);
    step();
    chk("bge_valid", bus.res_valid, 1);
    chk("bge_dest", bus.res_dest, 7);
    chk("bge_taken", bus.res_taken, 1);
    chk("bge_count_after", count, 0);
    step();
    chk("bge_strobe_drop", bus.res_valid, 0);
    chk("bge_dest_hold", bus.res_dest, 7);

    // compare table
    tv.push_back('{1, 32'hFFFF_FFFF, 32'd1, 2, 1'b1});
    tv.push_back('{0, 32'hFFFF_FFFB, 32'd3, 8, 1'b0});
    tv.push_back('{0, 32'd3, 32'd3, 9, 1'b1});
    tv.push_back('{3, 32'd7, 32'd7, 10, 1'b0});
    tv.push_back('{2, 32'h8000_0000, 32'h8000_0000, 11, 1'b1});
    tv.push_back('{1, 32'h8000_0000, 32'h7FFF_FFFF, 12, 1'b1});
`ifdef BRANCH_RS_UNSIGNED_EN
    tv.push_back('{5, 32'hFFFF_FFFF, 32'd1, 13, 1'b0});
    tv.push_back('{4, 32'hFFFF_FFFF, 32'd1, 14, 1'b1});
    tv.push_back('{6, 32'd4, 32'd4, 15, 1'b1});
`endif
    foreach (tv[k]) begin
      put(tv[k].m, tv[k].d, tv[k].a, tv[k].b, 1, 1, 0, 0);
      step();
      idle();
      step();
      chk($sformatf("cmp%0d_dest", k), bus.res_dest, 64'(tv[k].d));
      chk($sformatf("cmp%0d_taken", k), bus.res_taken, 64'(tv[k].t));
      step();
    end

    // BEQ waiting on tag 9; wrong-tag pulse on slot 8 first
    put(2, 3, 0, 4, 0, 1, 9, 0);
    step();
    idle();
    cdb(8, 4, 1);
    cdb(9, 99, 0);
    step();
    chk("snoop_wrong_tag", bus.res_valid, 0);
    idle();
    cdb(9, 4, 1);
    step();
    idle();
    chk("snoop_capture_edge", bus.res_valid, 0);
    step();
    chk("snoop_valid", bus.res_valid, 1);
    chk("snoop_dest", bus.res_dest, 3);
    chk("snoop_taken", bus.res_taken, 1);
    step();

    // fill all four entries on tag 5
    put(0, 1, 0, 0, 0, 1, 5, 0);
    step();
    put(1, 2, 0, 0, 0, 1, 5, 0);
    step();
    put(2, 3, 0, 10, 0, 1, 5, 0);
    step();
    put(3, 4, 0, 10, 0, 1, 5, 0);
    step();
    chk("full_count", count, 4);
    chk("full_ready", bus.issue_ready, 0);
    put(0, 9, 1, 1, 1, 1, 0, 0);
    step();
    idle();
    chk("full_ignore_count", count, 4);
    chk("full_ignore_res", bus.res_valid, 0);
    cdb(5, 10, 1);
    step();
    idle();
    chk("bcast_capture_edge", bus.res_valid, 0);
    step();
    chk("order0_dest", bus.res_dest, 1);
    chk("order0_taken", bus.res_taken, 1);
    chk("order0_ready", bus.issue_ready, 1);
    step();
    chk("order1_dest", bus.res_dest, 2);
    chk("order1_taken", bus.res_taken, 0);
    step();
    chk("order2_dest", bus.res_dest, 3);
    chk("order2_taken", bus.res_taken, 1);
    step();
    chk("order3_valid", bus.res_valid, 1);
    chk("order3_dest", bus.res_dest, 4);
    chk("order3_taken", bus.res_taken, 0);
    chk("order_count", count, 0);
    step();
    chk("dropped_issue_absent", bus.res_valid, 0);

    // same-cycle CDB bypass on qk
    put(1, 5, 1, 0, 1, 0, 0, 6);
    cdb(6, 7, 1);
    step();
    idle();
    chk("bypass_edge1", bus.res_valid, 0);
    step();
    chk("bypass_valid", bus.res_valid, 1);
    chk("bypass_dest", bus.res_dest, 5);
    chk("bypass_taken", bus.res_taken, 1);
    step();

    // middle removal with simultaneous issue, then compaction order
    put(2, 12, 0, 3, 0, 1, 1, 0);
    step();
    put(3, 13, 1, 2, 1, 1, 0, 0);
    step();
    put(0, 14, 0, 100, 0, 1, 2, 0);
    step();
    idle();
    chk("mid_dest", bus.res_dest, 13);
    chk("mid_valid", bus.res_valid, 1);
    chk("mid_count", count, 2);
    cdb(1, 3, 1);
    cdb(2, 32'hFFFF_FFFB, 1);
    step();
    idle();
    chk("compact_wait", bus.res_valid, 0);
    step();
    chk("compact0_dest", bus.res_dest, 12);
    chk("compact0_taken", bus.res_taken, 1);
    step();
    chk("compact1_dest", bus.res_dest, 14);
    chk("compact1_taken", bus.res_taken, 0);
    chk("compact_count", count, 0);
    step();

    // flush with 3 held (last one about to select) plus a concurrent issue
    put(2, 20, 0, 0, 0, 1, 3, 0);
    step();
    put(2, 21, 0, 0, 0, 1, 3, 0);
    step();
    put(0, 6, 1, 0, 1, 1, 0, 0);
    step();
    chk("pre_flush_count", count, 3);
    put(0, 11, 1, 0, 1, 1, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("flush_count", count, 0);
    chk("flush_res_valid", bus.res_valid, 0);
    chk("flush_res_dest", bus.res_dest, 0);
    chk("flush_ready", bus.issue_ready, 1);
    cdb(3, 0, 1);
    step();
    idle();
    chk("flush_none_a", bus.res_valid, 0);
    step();
    chk("flush_none_b", bus.res_valid, 0);
    step();
    chk("flush_none_c", bus.res_valid, 0);

    // reset mid-stream
    put(0, 15, 5, 3, 1, 1, 0, 0);
    step();
    put(1, 6, 1, 2, 1, 1, 0, 0);
    step();
    idle();
    chk("pre_rst_dest", bus.res_dest, 15);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_res_valid", bus.res_valid, 0);
    chk("mrst_res_dest", bus.res_dest, 0);
    chk("mrst_res_taken", bus.res_taken, 0);
    chk("mrst_count", count, 0);
    chk("mrst_ready", bus.issue_ready, 1);
    step();
    chk("mrst_no_result", bus.res_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end
endmodule

// File: doc/branch_rs_multi.md
Name: branch_rs_multi

Overview:
Multi-entry branch reservation station for the Tomasulo core. It is the successor to the single-entry BGE-only station.
- Holds up to ENTRIES branch ops.
- Snoops the per-ROB-slot CDB data/valid buses to resolve pending operands.
- Evaluates one of four compare modes.
- Issues one resolved result per cycle, oldest ready first, tagged with its ROB index.
- Sits between the issue stage (fed from the register file / ROB operand read) and the ROB commit logic.

Parameters:
WORD_SIZE, 32, operand width
RB_SIZE, 16, ROB entry count (CDB slot count)
RB_INDEX, 4, ROB index width, log2(RB_SIZE)
ENTRIES, 4, station depth, 2..8

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
flush  in  1  discard all entries and any pending result (mispredict recovery)
issue_valid  in  1  issue request this cycle
issue_ready  out  1  a free entry exists; equals (count < ENTRIES) from registered state
issue_mode  in  2  00 BGE, 01 BLT, 10 BEQ, 11 BNE
issue_dest  in  RB_INDEX  ROB index of the branch
issue_vj, issue_vk  in  WORD_SIZE  operand values, valid when the matching rdy bit is 1
issue_rdyj, issue_rdyk  in  1  operand already available
issue_qj, issue_qk  in  RB_INDEX  producer ROB tag when not ready
cdb_data  in  WORD_SIZE*RB_SIZE  slot i data at bits [(i+1)*WORD_SIZE-1 : i*WORD_SIZE]
cdb_valid  in  RB_SIZE  slot i data valid
res_valid  out  1  result strobe, one cycle per branch
res_dest  out  RB_INDEX  ROB index of the result
res_taken  out  1  compare outcome
count  out  log2(ENTRIES)+1  occupied entries

Behaviour:
- Reset (sync, highest priority):
  - All entries invalid; count=0, issue_ready=1.
  - res_valid=0, res_dest=0, res_taken=0.
- Flush (priority below reset, above everything else):
  - Same clearing effect as reset.
  - Issue in the same cycle is dropped.
  - res_valid=0 after the edge.
- Entry fields: valid, mode, dest, Vj, Vk, rdyj, rdyk, Qj, Qk.
- Entries are kept in age order. This is a compacting queue: index 0 is oldest, and a removed slot shifts younger entries down.
- Issue (issue_valid && issue_ready):
  - Write the next free slot.
  - Per operand: if rdy, capture v. Else if cdb_valid[q]=1 this cycle, capture cdb_data slot q and mark ready (same-cycle bypass). Else store the tag.
- Snoop: every cycle, each valid entry with a non-ready operand whose cdb_valid[Q]=1 captures that data and sets rdy.
- Select:
  - An entry is eligible when valid, rdyj and rdyk are all set in the registered state at the start of the cycle. Same-cycle CDB capture makes the entry eligible the following cycle.
  - The lowest-index eligible entry is selected.
  - At the edge: res_valid<=1, res_dest<=dest, res_taken<=compare(mode, Vj, Vk), and the entry is removed.
  - res_valid is 0 in any cycle with no eligible entry. res_dest and res_taken hold their last value.
- Compare rules:
  - Signed two's complement, full WORD_SIZE.
  - BGE: Vj>=Vk. BLT: Vj<Vk. BEQ: Vj==Vk. BNE: Vj!=Vk.
- Latency:
  - Issue with both operands ready at edge N gives res_valid high N+1..N+2.
  - Operand arriving on the CDB at edge M gives result at M+1.
- Throughput: one result per cycle.
- Simultaneous issue and select:
  - Both happen.
  - The new entry lands at position count-1 after compaction.
  - count is unchanged.
- Full: issue_ready=0 when count==ENTRIES, even if a select frees a slot that cycle (no same-cycle reuse). An issue_valid while not ready is ignored.
- Wrong-tag safety: only the tagged slot's cdb_valid bit is examined. Activity on other slots has no effect.

Optional Feature:
BRANCH_RS_UNSIGNED_EN:
- When defined, issue_mode is 3 bits and the entry stores bit 2. Bit 2 = 1 selects unsigned compare for BGE/BLT (BGEU/BLTU); BEQ/BNE are unaffected.
- When undefined, issue_mode is 2 bits and all compares are signed.

Test Plan:
- Reset, then issue BGE with Vj=5, Vk=3, both ready, dest=7 -> one cycle later res_valid=1, res_dest=7, res_taken=1. The next cycle has res_valid=0 and count=0.
- Issue BLT with Vj=-1 (0xFFFFFFFF), Vk=1, ready, dest=2 -> res_taken=1. With BRANCH_RS_UNSIGNED_EN and mode=101 -> res_taken=0.
- Issue BEQ with qj=9 not ready, Vk=4, dest=3. Two cycles later drive cdb_valid[9]=1, slot 9 data=4 -> res_valid the next cycle with res_dest=3, res_taken=1. cdb_valid[8] pulses beforehand cause no result.
- Fill 4 entries (dest 1..4), all waiting on tag 5 -> issue_ready=0, a 5th issue is ignored. Then broadcast tag 5 -> results for dest 1,2,3,4 on four consecutive cycles, in order.
- Issue an entry with qk=6 while cdb_valid[6]=1 in the same cycle (bypass), Vj ready -> result appears exactly 2 edges after issue.
- Hold 3 entries, assert flush together with issue_valid -> count=0, res_valid=0, and no later result for any flushed dest. Assert reset mid-stream -> all outputs take their reset values.
